high_res_timer_driver: RTL and testbench

Avalon-MM initiator that programs and services the 16-bit-register interval timer peripheral in the Nios system, so hardware logic can use the timer without the CPU. It accepts simple commands (configure/start, snapshot, stop) on a valid/ready port. It issues the matching register writes and reads, and returns a 32-bit counter snapshot. It also services the timer's IRQ autonomously, clearing the timeout status and counting timeouts.

---
 rtl/high_res_timer_driver.sv | 184 ++++++++++++++++++
 tb/tb_high_res_timer_driver.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/high_res_timer_driver.sv
// Avalon-MM initiator that configures, stops and snapshots the interval timer and services its IRQ (TIMER_DRV_SNAPSHOT_EN enables SNAPSHOT).
// Latency accept->rsp_valid: CONFIG 4, STOP 2, SNAPSHOT 6 (1 when disabled), reserved 1; IRQ clear write 1 cycle after detect.
// Backpressure: cmd_ready only in IDLE with no pending IRQ; every bus access holds and stalls while av_waitrequest is high.
module high_res_timer_driver #(
    parameter int TICK_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [31:0]       cmd_period,
    input  logic              cmd_continuous,
    input  logic              cmd_irq_en,
    output logic              rsp_valid,
    output logic [31:0]       rsp_snapshot,
    output logic [TICK_W-1:0] tick_count,
    input  logic              timer_irq,
    output logic [2:0]        av_address,
    output logic              av_chipselect,
    output logic              av_write_n,
    output logic [15:0]       av_writedata,
    input  logic [15:0]       av_readdata,
    input  logic              av_waitrequest
);
    localparam logic [1:0] OP_CONFIG   = 2'd0;
    localparam logic [1:0] OP_SNAPSHOT = 2'd1;
    localparam logic [1:0] OP_STOP     = 2'd2;

    typedef enum logic [3:0] {
        IDLE, CFG_PL, CFG_PH, CFG_CTRL, STOP_W,
`ifdef TIMER_DRV_SNAPSHOT_EN
        SNAP_W, SNAP_RL, SNAP_CL, SNAP_RH, SNAP_CH,
`endif
        IRQ_CLR, RESP
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] period_q;
    logic        cont_q, irq_en_q;
    logic        tick_inc;
`ifdef TIMER_DRV_SNAPSHOT_EN
    logic [15:0] snap_lo_q;
    logic        cap_lo, cap_hi;
`endif

    always_comb begin
        state_d       = state_q;
        cmd_ready     = 1'b0;
        rsp_valid     = 1'b0;
        av_chipselect = 1'b0;
        av_write_n    = 1'b1;
        av_address    = 3'd0;
        av_writedata  = 16'h0000;
        tick_inc      = 1'b0;
`ifdef TIMER_DRV_SNAPSHOT_EN
        cap_lo        = 1'b0;
        cap_hi        = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                cmd_ready = !timer_irq;
                if (timer_irq) begin
                    state_d = IRQ_CLR;
                end else if (cmd_valid) begin
                    case (cmd_op)
                        OP_CONFIG:   state_d = CFG_PL;
                        OP_STOP:     state_d = STOP_W;
`ifdef TIMER_DRV_SNAPSHOT_EN
                        OP_SNAPSHOT: state_d = SNAP_W;
`else
                        OP_SNAPSHOT: state_d = RESP;
`endif
                        default:     state_d = RESP;
                    endcase
                end
            end
            IRQ_CLR: begin
                av_chipselect = 1'b1;
                av_write_n    = 1'b0;
                if (!av_waitrequest) begin
                    tick_inc = 1'b1;
                    state_d  = IDLE;
                end
            end
            CFG_PL: begin
                av_chipselect = 1'b1;
                av_write_n    = 1'b0;
                av_address    = 3'd2;
                av_writedata  = period_q[15:0];
                if (!av_waitrequest) state_d = CFG_PH;
            end
            CFG_PH: begin
                av_chipselect = 1'b1;
                av_write_n    = 1'b0;
                av_address    = 3'd3;
                av_writedata  = period_q[31:16];
                if (!av_waitrequest) state_d = CFG_CTRL;
            end
            CFG_CTRL: begin
                av_chipselect = 1'b1;
                av_write_n    = 1'b0;
                av_address    = 3'd1;
                av_writedata  = {12'h000, 1'b0, 1'b1, cont_q, irq_en_q};
                if (!av_waitrequest) state_d = RESP;
            end
            STOP_W: begin
                // Mode bits are re-sent from the last CONFIG so stopping does not alter them.
                av_chipselect = 1'b1;
                av_write_n    = 1'b0;
                av_address    = 3'd1;
                av_writedata  = {12'h000, 1'b1, 1'b0, cont_q, irq_en_q};
                if (!av_waitrequest) state_d = RESP;
            end
`ifdef TIMER_DRV_SNAPSHOT_EN
            SNAP_W: begin
                av_chipselect = 1'b1;
                av_write_n    = 1'b0;
                av_address    = 3'd4;
                if (!av_waitrequest) state_d = SNAP_RL;
            end
            SNAP_RL: begin
                av_chipselect = 1'b1;
                av_address    = 3'd4;
                if (!av_waitrequest) state_d = SNAP_CL;
            end
            SNAP_CL: begin
                cap_lo  = 1'b1;
                state_d = SNAP_RH;
            end
            SNAP_RH: begin
                av_chipselect = 1'b1;
                av_address    = 3'd5;
                if (!av_waitrequest) state_d = SNAP_CH;
            end
            SNAP_CH: begin
                cap_hi  = 1'b1;
                state_d = RESP;
            end
`endif
            RESP: begin
                rsp_valid = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            period_q   <= '0;
            cont_q     <= 1'b0;
            irq_en_q   <= 1'b0;
            tick_count <= '0;
        end else begin
            state_q <= state_d;
            if (cmd_valid && cmd_ready && cmd_op == OP_CONFIG) begin
                period_q <= cmd_period;
                cont_q   <= cmd_continuous;
                irq_en_q <= cmd_irq_en;
            end
            if (tick_inc) tick_count <= tick_count + TICK_W'(1);
        end
    end

`ifdef TIMER_DRV_SNAPSHOT_EN
    // Low half is staged so rsp_snapshot only ever shows a coherent 32-bit value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            snap_lo_q    <= '0;
            rsp_snapshot <= '0;
        end else begin
            if (cap_lo) snap_lo_q <= av_readdata;
            if (cap_hi) rsp_snapshot <= {av_readdata, snap_lo_q};
        end
    end
`else
    logic unused_readdata;
    assign unused_readdata = ^av_readdata;
    assign rsp_snapshot    = '0;
`endif

endmodule

// File: tb/tb_high_res_timer_driver.sv
// Randomized bench for high_res_timer_driver: bus slave with timer IRQ behaviour plus a transaction-level reference model.
module tb_high_res_timer_driver;
    localparam int TW = 4;
`ifdef TIMER_DRV_SNAPSHOT_EN
    localparam bit SNAP_EN = 1'b1;
`else
    localparam bit SNAP_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          cmd_valid, cmd_ready;
    logic [1:0]    cmd_op;
    logic [31:0]   cmd_period;
    logic          cmd_continuous, cmd_irq_en;
    logic          rsp_valid;
    logic [31:0]   rsp_snapshot;
    logic [TW-1:0] tick_count;
    logic          timer_irq;
    logic [2:0]    av_address;
    logic          av_chipselect, av_write_n;
    logic [15:0]   av_writedata, av_readdata;
    logic          av_waitrequest;

    high_res_timer_driver #(.TICK_W(TW)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_period(cmd_period), .cmd_continuous(cmd_continuous), .cmd_irq_en(cmd_irq_en),
        .rsp_valid(rsp_valid), .rsp_snapshot(rsp_snapshot), .tick_count(tick_count),
        .timer_irq(timer_irq),
        .av_address(av_address), .av_chipselect(av_chipselect), .av_write_n(av_write_n),
        .av_writedata(av_writedata), .av_readdata(av_readdata), .av_waitrequest(av_waitrequest)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bus slave / monitor state, shared with the stimulus process.
    logic [19:0] bus_q[$];
    int cyc = 0, clr_cnt = 0, clr_bad = 0, raise_cnt = 0;
    int acc_cnt = 0, acc_cyc = 0, rsp_cnt = 0, rsp_cyc = 0;
    int stab_err = 0, rdy_err = 0, wait_mode = 0, stall_cnt = 0;
    logic raise_req = 1'b0;
    logic [15:0] rd_lo = 16'h0, rd_hi = 16'h0;

    // Reference model state.
    logic        m_cont = 1'b0, m_ie = 1'b0;
    logic [31:0] m_snap = 32'h0;
    int          exp_rsp = 0;

    initial begin
        logic rd_acc, drop, p_stall, p_wn;
        logic [2:0] rd_addr, p_addr;
        logic [15:0] p_dat;
        p_stall = 1'b0; p_wn = 1'b1; p_addr = 3'd0; p_dat = 16'h0; rd_addr = 3'd0;
        timer_irq = 1'b0; av_readdata = 16'h0; av_waitrequest = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            rd_acc = 1'b0;
            drop   = 1'b0;
            if (reset_n) begin
                if (p_stall && !(av_chipselect && av_address == p_addr && av_write_n == p_wn &&
                                 av_writedata == p_dat)) stab_err++;
                p_stall = av_chipselect && av_waitrequest;
                p_addr = av_address; p_wn = av_write_n; p_dat = av_writedata;
                if (av_chipselect && !av_waitrequest) begin
                    if (!av_write_n && av_address == 3'd0) begin
                        clr_cnt++;
                        drop = 1'b1;
                        if (av_writedata != 16'h0) clr_bad++;
                    end else begin
                        bus_q.push_back({av_write_n, av_address, av_write_n ? 16'h0 : av_writedata});
                    end
                    if (av_write_n) begin
                        rd_acc = 1'b1;
                        rd_addr = av_address;
                    end
                end
                if (av_chipselect && av_waitrequest && av_address == 3'd3) stall_cnt++;
                if (cmd_valid && cmd_ready) begin acc_cnt++; acc_cyc = cyc; end
                if (rsp_valid) begin rsp_cnt++; rsp_cyc = cyc; end
                if (timer_irq && cmd_ready) rdy_err++;
            end else begin
                p_stall = 1'b0;
            end
            @(posedge clk); #1;
            av_readdata = rd_acc ? (rd_addr == 3'd4 ? rd_lo : rd_addr == 3'd5 ? rd_hi : 16'hDEAD)
                                 : 16'($urandom);
            if (drop) timer_irq = 1'b0;
            else if (raise_req && !timer_irq) begin
                timer_irq = 1'b1;
                raise_req = 1'b0;
                raise_cnt++;
            end
            case (wait_mode)
                1:       av_waitrequest = ($urandom_range(2) == 0);
                2:       av_waitrequest = av_chipselect && av_address == 3'd3 && stall_cnt < 4;
                default: av_waitrequest = 1'b0;
            endcase
        end
    end

    task automatic do_cmd(input logic [1:0] op, input logic [31:0] per, input logic c,
                          input logic ie, input int wm, input logic irq_mid);
        logic [19:0] exp_q[$];
        int lat, a0, r0;
        logic ok;
        lat = 1;
        case (op)
            2'd0: begin
                exp_q.push_back({1'b0, 3'd2, per[15:0]});
                exp_q.push_back({1'b0, 3'd3, per[31:16]});
                exp_q.push_back({1'b0, 3'd1, 12'h000, 2'b01, c, ie});
                lat = (wm == 2) ? 8 : 4;
                m_cont = c; m_ie = ie;
            end
            2'd1: if (SNAP_EN) begin
                exp_q.push_back({1'b0, 3'd4, 16'h0});
                exp_q.push_back({1'b1, 3'd4, 16'h0});
                exp_q.push_back({1'b1, 3'd5, 16'h0});
                lat = 6;
                m_snap = {rd_hi, rd_lo};
            end
            2'd2: begin
                exp_q.push_back({1'b0, 3'd1, 12'h000, 2'b10, m_cont, m_ie});
                lat = 2;
            end
            default: lat = 1;
        endcase
        wait_mode = wm; stall_cnt = 0; bus_q.delete();
        a0 = acc_cnt; r0 = rsp_cnt;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = op; cmd_period = per; cmd_continuous = c; cmd_irq_en = ie;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #1;
            if (acc_cnt != a0) begin ok = 1'b1; break; end
        end
        check_eq("accept", ok, 1'b1);
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_period = $urandom;
        cmd_continuous = 1'($urandom); cmd_irq_en = 1'($urandom);
        if (irq_mid) raise_req = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (rsp_cnt != r0) begin ok = 1'b1; break; end
            @(negedge clk); #1;
        end
        check_eq("rsp", ok, 1'b1);
        exp_rsp++;
        if (wm != 1) check_eq($sformatf("latency_op%0d", op), rsp_cyc - acc_cyc, lat);
        check_eq($sformatf("bus_count_op%0d", op), bus_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            check_eq($sformatf("bus%0d_op%0d", i, op), (i < bus_q.size()) ? bus_q[i] : 20'hFFFFF, exp_q[i]);
        check_eq("snapshot", rsp_snapshot, m_snap);
        wait_mode = 0;
    endtask

    task automatic drain_irq();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #1;
            if (!timer_irq && !raise_req) break;
        end
        repeat (3) @(negedge clk);
        #1;
    endtask

    initial begin
        logic ok;
        int c0;
        cmd_valid = 1'b0; cmd_op = 2'd0; cmd_period = 32'h0; cmd_continuous = 1'b0; cmd_irq_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_cs", av_chipselect, 1'b0);
        check_eq("rst_wn", av_write_n, 1'b1);
        check_eq("rst_addr", av_address, 3'd0);
        check_eq("rst_wdat", av_writedata, 16'h0);
        check_eq("rst_rsp", rsp_valid, 1'b0);
        check_eq("rst_snap", rsp_snapshot, 32'h0);
        check_eq("rst_tick", tick_count, 0);
        check_eq("rst_ready", cmd_ready, 1'b1);
        @(negedge clk); #2 reset_n = 1'b1;

        do_cmd(2'd0, 32'h0001_86A0, 1'b1, 1'b1, 0, 1'b0);
        rd_lo = 16'h1234; rd_hi = 16'hABCD;
        do_cmd(2'd1, $urandom, 1'($urandom), 1'($urandom), 0, 1'b0);

        for (int k = 0; k < 3; k++) begin
            c0 = clr_cnt;
            raise_req = 1'b1;
            for (int i = 0; i < 50; i++) begin
                @(negedge clk); #1;
                if (clr_cnt != c0) break;
            end
            repeat (3) @(negedge clk);
        end
        #1;
        check_eq("irq_ticks", tick_count, 3);
        check_eq("irq_clears", clr_cnt, 3);

        do_cmd(2'd0, $urandom, 1'b1, 1'b0, 0, 1'b0);
        do_cmd(2'd2, $urandom, 1'($urandom), 1'($urandom), 0, 1'b0);
        do_cmd(2'd0, $urandom, 1'($urandom), 1'($urandom), 2, 1'b0);
        do_cmd(2'd3, $urandom, 1'($urandom), 1'($urandom), 0, 1'b0);

        for (int n = 0; n < 60; n++) begin
            rd_lo = 16'($urandom); rd_hi = 16'($urandom);
            do_cmd(2'($urandom), $urandom, 1'($urandom), 1'($urandom),
                   int'($urandom_range(1)), 1'($urandom_range(1)));
        end
        drain_irq();
        check_eq("ticks_wrap", tick_count, raise_cnt % (1 << TW));
        check_eq("clears", clr_cnt, raise_cnt);
        check_eq("clear_data", clr_bad, 0);
        check_eq("stall_stable", stab_err, 0);
        check_eq("ready_during_irq", rdy_err, 0);
        check_eq("rsp_pulses", rsp_cnt, exp_rsp);

        // Reset in the middle of the CONFIG period-high write.
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = 2'd0; cmd_period = 32'h5555_AAAA; cmd_continuous = 1'b1; cmd_irq_en = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #1;
            if (av_chipselect && av_address == 3'd3) begin ok = 1'b1; break; end
        end
        check_eq("rst_mid_reach", ok, 1'b1);
        reset_n = 1'b0;
        #1;
        check_eq("rst_mid_cs", av_chipselect, 1'b0);
        check_eq("rst_mid_wn", av_write_n, 1'b1);
        check_eq("rst_mid_tick", tick_count, 0);
        cmd_valid = 1'b0;
        m_cont = 1'b0; m_ie = 1'b0; m_snap = 32'h0;
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b1;
        raise_cnt = 0; clr_cnt = 0; bus_q.delete();
        repeat (10) @(negedge clk);
        #1;
        check_eq("rst_no_writes", bus_q.size(), 0);
        check_eq("rst_no_rsp", rsp_cnt, exp_rsp);
        do_cmd(2'd2, $urandom, 1'($urandom), 1'($urandom), 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
